// File: rtl/train_pkg.sv
// Shared types for the training data buffer: vector type and replay FSM states.
package train_pkg;

    localparam int default_data_size = 16;
    localparam int default_size      = 3;

    typedef logic [default_data_size*default_size-1:0] vec_t;

    typedef enum logic [1:0] {
        FORWARD = 2'd0,
        REPLAY  = 2'd1,
        DONE    = 2'd2
    } buf_state_e;

endpackage

// File: rtl/train_pair_fifo.sv
// Circular storage for (z, predict_value) pairs with first-word-fall-through read port.
module train_pair_fifo #(
    parameter int width = 48,
    parameter int depth = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  logic [width-1:0]            in_z,
    input  logic [width-1:0]            in_predict,
    output logic [width-1:0]            out_z,
    output logic [width-1:0]            out_predict,
    output logic [$clog2(depth):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = ptr_w + 1;

    logic [width-1:0] mem_z [depth];
    logic [width-1:0] mem_p [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == cnt_w'(depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Depth is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_z[i] <= '0;
                mem_p[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem_z[wr_ptr] <= in_z;
                mem_p[wr_ptr] <= in_predict;
                wr_ptr        <= wr_ptr + ptr_w'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_z       = mem_z[rd_ptr];
    assign out_predict = mem_p[rd_ptr];

endmodule

// File: rtl/train_data_buffer.sv
// Captures forward-pass (z, predict_value) pairs and replays them oldest-first for training.
module train_data_buffer
    import train_pkg::*;
#(
    parameter int data_size = default_data_size,
    parameter int size      = default_size,
    parameter int depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [data_size*size-1:0]   wr_z,
    input  logic [data_size*size-1:0]   wr_predict,
    input  logic                        train_start,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [data_size*size-1:0]   z,
    output logic [data_size*size-1:0]   predict_value_old,
    output logic                        use_z,
    output logic                        train_done,
    output logic [$clog2(depth):0]      count
);

    localparam int width = data_size * size;
    localparam int cnt_w = $clog2(depth) + 1;

    buf_state_e state;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    assign wr_ready   = (state == FORWARD) && !full;
    assign rd_valid   = (state == REPLAY) && !empty;
    assign use_z      = (state == REPLAY);
    assign train_done = (state == DONE);

    // clear must win over any storage update in the same cycle.
    assign push = wr_valid && wr_ready && !clear;
    assign pop  = rd_valid && rd_ready && !clear;

    train_pair_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .in_z        (wr_z),
        .in_predict  (wr_predict),
        .out_z       (z),
        .out_predict (predict_value_old),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FORWARD;
        end else if (clear) begin
            state <= FORWARD;
        end else begin
            case (state)
                FORWARD: begin
                    // A pair pushed alongside train_start is part of this replay.
                    if (train_start && (!empty || push)) begin
                        state <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (pop && (count == cnt_w'(1))) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= FORWARD;
                default: state <= FORWARD;
            endcase
        end
    end

endmodule

// File: tb/tb_train_data_buffer.sv
// Randomized self-checking bench for train_data_buffer against a queue-based behavioural model.
module tb_train_data_buffer;

    localparam int W     = 48;
    localparam int DEPTH = 4;

    typedef logic [W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       wr_valid;
    logic       wr_ready;
    vec_t       wr_z;
    vec_t       wr_predict;
    logic       train_start;
    logic       rd_ready;
    logic       rd_valid;
    vec_t       z;
    vec_t       predict_value_old;
    logic       use_z;
    logic       train_done;
    logic [2:0] count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural model: 0 = capturing, 1 = replaying, 2 = done pulse
    vec_t mq_z[$];
    vec_t mq_p[$];
    int   mmode = 0;

    train_data_buffer #(.data_size(16), .size(3), .depth(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear             (clear),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_z              (wr_z),
        .wr_predict        (wr_predict),
        .train_start       (train_start),
        .rd_ready          (rd_ready),
        .rd_valid          (rd_valid),
        .z                 (z),
        .predict_value_old (predict_value_old),
        .use_z             (use_z),
        .train_done        (train_done),
        .count             (count)
    );

    always #5 clk = ~clk;

    function automatic vec_t rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [6:0] exp_ctrl();
        int n;
        n = mq_z.size();
        return {mmode == 1, mmode == 2, (mmode == 1) && (n > 0), (mmode == 0) && (n < DEPTH), 3'(n)};
    endfunction

    function automatic void model_step();
        if (clear) begin
            mq_z.delete();
            mq_p.delete();
            mmode = 0;
        end else if (mmode == 0) begin
            if (wr_valid && mq_z.size() < DEPTH) begin
                mq_z.push_back(wr_z);
                mq_p.push_back(wr_predict);
            end
            if (train_start && mq_z.size() > 0) mmode = 1;
        end else if (mmode == 1) begin
            if (rd_ready && mq_z.size() > 0) begin
                void'(mq_z.pop_front());
                void'(mq_p.pop_front());
                if (mq_z.size() == 0) mmode = 2;
            end
        end else begin
            mmode = 0;
        end
    endfunction

    function automatic void model_reset();
        mq_z.delete();
        mq_p.delete();
        mmode = 0;
    endfunction

    task automatic cyc(input bit v, input vec_t dz, input vec_t dp, input bit s, input bit r, input bit c);
        @(negedge clk);
        wr_valid    = v;
        wr_z        = dz;
        wr_predict  = dp;
        train_start = s;
        rd_ready    = r;
        clear       = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        checks++;
        if ({use_z, train_done, rd_valid, wr_ready, count} !== 7'b0001000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want %b", {use_z, train_done, rd_valid, wr_ready, count}, 7'b0001000);
        end else passes++;
        checks++;
        if (z !== '0 || predict_value_old !== '0) begin
            fails++;
            $display("FAIL reset_data: got z=%h pv=%h want 0", z, predict_value_old);
        end else passes++;
    endtask

    task automatic test_replay_basic();
        int uz_cycles;
        int done_at;
        vec_t ez;
        vec_t ep;
        uz_cycles = 0;
        done_at   = -1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, {3{16'h0001 + 16'(i)}}, {3{16'h0101 + 16'(i)}}, 0, 0, 0);
            tick();
        end
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            cyc(0, '0, '0, 0, 1, 0);
            checks++;
            if ({use_z, train_done, rd_valid, wr_ready, count} !== exp_ctrl()) begin
                fails++;
                $display("FAIL basic_ctrl cyc%0d: got %b want %b", k, {use_z, train_done, rd_valid, wr_ready, count}, exp_ctrl());
            end else passes++;
            if (k < 3) begin
                ez = {3{16'h0001 + 16'(k)}};
                ep = {3{16'h0101 + 16'(k)}};
                checks++;
                if (z !== ez || predict_value_old !== ep) begin
                    fails++;
                    $display("FAIL basic_order pop%0d: got z=%h pv=%h want z=%h pv=%h", k, z, predict_value_old, ez, ep);
                end else passes++;
            end
            if (use_z) uz_cycles++;
            if (train_done && done_at < 0) done_at = k;
            tick();
        end
        checks++;
        if (uz_cycles !== 3 || done_at !== 3) begin
            fails++;
            $display("FAIL basic_timing: got use_z_cycles=%0d done_at=%0d want 3 and 3", uz_cycles, done_at);
        end else passes++;
    endtask

    task automatic test_full();
        int pops;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, rand_vec(), rand_vec(), 0, 0, 0);
            if (i == 4) begin
                checks++;
                if (wr_ready !== 1'b0 || count !== 3'd4) begin
                    fails++;
                    $display("FAIL full_gate: got wr_ready=%b count=%0d want 0 and 4", wr_ready, count);
                end else passes++;
            end
            tick();
        end
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            cyc(0, '0, '0, 0, 1, 0);
            if (rd_valid) begin
                pops++;
                checks++;
                if (z !== mq_z[0] || predict_value_old !== mq_p[0]) begin
                    fails++;
                    $display("FAIL full_data pop%0d: got z=%h want %h", k, z, mq_z[0]);
                end else passes++;
            end
            tick();
        end
        checks++;
        if (pops !== 4) begin
            fails++;
            $display("FAIL full_pops: got %0d want 4", pops);
        end else passes++;
    endtask

    task automatic test_empty_start();
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            cyc(0, '0, '0, 0, 0, 0);
            checks++;
            if ({use_z, train_done, wr_ready, count} !== 6'b001000) begin
                fails++;
                $display("FAIL empty_start cyc%0d: got %b want %b", k, {use_z, train_done, wr_ready, count}, 6'b001000);
            end else passes++;
            tick();
        end
    endtask

    task automatic test_stall();
        vec_t prev_z;
        bit   prev_hold;
        int   pops;
        pops      = 0;
        prev_hold = 0;
        prev_z    = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, rand_vec(), rand_vec(), 0, 0, 0);
            tick();
        end
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            cyc(0, '0, '0, 0, (k % 2) == 0, 0);
            checks++;
            if ({use_z, train_done, rd_valid, wr_ready, count} !== exp_ctrl()) begin
                fails++;
                $display("FAIL stall_ctrl cyc%0d: got %b want %b", k, {use_z, train_done, rd_valid, wr_ready, count}, exp_ctrl());
            end else passes++;
            if (rd_valid) begin
                checks++;
                if (z !== mq_z[0] || predict_value_old !== mq_p[0] || (prev_hold && z !== prev_z)) begin
                    fails++;
                    $display("FAIL stall_data cyc%0d: got z=%h want %h", k, z, mq_z[0]);
                end else passes++;
                if (rd_ready) pops++;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_z    = z;
            tick();
        end
        checks++;
        if (pops !== 4) begin
            fails++;
            $display("FAIL stall_pops: got %0d want 4", pops);
        end else passes++;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2; i++) begin
            cyc(1, rand_vec(), rand_vec(), 0, 0, 0);
            tick();
        end
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        cyc(0, '0, '0, 0, 1, 0);
        tick();
        cyc(0, '0, '0, 0, 0, 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            cyc(0, '0, '0, 0, 0, 0);
            checks++;
            if ({use_z, train_done, rd_valid, wr_ready, count} !== 7'b0001000) begin
                fails++;
                $display("FAIL clear_state cyc%0d: got %b want %b", k, {use_z, train_done, rd_valid, wr_ready, count}, 7'b0001000);
            end else passes++;
            tick();
        end
    endtask

    task automatic test_reset_mid_replay();
        for (int i = 0; i < 3; i++) begin
            cyc(1, rand_vec(), rand_vec(), 0, 0, 0);
            tick();
        end
        cyc(0, '0, '0, 1, 0, 0);
        tick();
        cyc(0, '0, '0, 0, 1, 0);
        tick();
        cyc(0, '0, '0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({use_z, train_done, rd_valid, wr_ready, count} !== 7'b0001000) begin
            fails++;
            $display("FAIL async_reset_ctrl: got %b want %b", {use_z, train_done, rd_valid, wr_ready, count}, 7'b0001000);
        end else passes++;
        checks++;
        if (z !== '0 || predict_value_old !== '0) begin
            fails++;
            $display("FAIL async_reset_data: got z=%h pv=%h want 0", z, predict_value_old);
        end else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                cyc(1, rand_vec(), rand_vec(), 0, 0, 0);
                tick();
            end
            cyc(0, '0, '0, 1, 0, 0);
            tick();
            for (int k = 0; k < 4; k++) begin
                cyc(0, '0, '0, 0, 1, 0);
                checks++;
                if ({use_z, train_done, rd_valid, wr_ready, count} !== exp_ctrl()) begin
                    fails++;
                    $display("FAIL wrap_ctrl r%0d cyc%0d: got %b want %b", r, k, {use_z, train_done, rd_valid, wr_ready, count}, exp_ctrl());
                end else passes++;
                if (rd_valid) begin
                    checks++;
                    if (z !== mq_z[0] || predict_value_old !== mq_p[0]) begin
                        fails++;
                        $display("FAIL wrap_data r%0d cyc%0d: got z=%h want %h", r, k, z, mq_z[0]);
                    end else passes++;
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 1), rand_vec(), rand_vec(), $urandom_range(0, 5) == 0,
                $urandom_range(0, 1), $urandom_range(0, 40) == 0);
            checks++;
            if ({use_z, train_done, rd_valid, wr_ready, count} !== exp_ctrl()) begin
                fails++;
                $display("FAIL random_ctrl cyc%0d: got %b want %b", k, {use_z, train_done, rd_valid, wr_ready, count}, exp_ctrl());
            end else passes++;
            if (mmode == 1 && mq_z.size() > 0) begin
                checks++;
                if (z !== mq_z[0] || predict_value_old !== mq_p[0]) begin
                    fails++;
                    $display("FAIL random_data cyc%0d: got z=%h pv=%h want z=%h pv=%h", k, z, predict_value_old, mq_z[0], mq_p[0]);
                end else passes++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        wr_valid    = 1'b0;
        wr_z        = '0;
        wr_predict  = '0;
        train_start = 1'b0;
        rd_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_replay_basic();
        test_full();
        test_empty_start();
        test_stall();
        test_clear();
        test_reset_mid_replay();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
